// File: rtl/dpram_sclk_pkg.sv
// ============================================================================
//  Module      : dpram_sclk_pkg
//  Description : Shared types and helpers for the byte-write single-clock
//                simple dual-port RAM (dpram_sclk_bw).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_sclk_pkg;

    // Sweep controller states: zeroing the array, or open for traffic.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dpram_state_t;

    // Widest lane the parity helper accepts; narrower lanes are zero-extended,
    // which leaves the parity unchanged.
    localparam int c_lane_max = 64;

    // Number of byte lanes in one word.
    function automatic int nb_of(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // Even-parity bit: makes the total count of ones in {par, lane} even.
    function automatic logic even_par(input logic [c_lane_max-1:0] lane);
        return ^lane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_sclk_lane.sv
// ============================================================================
//  Module      : dpram_sclk_lane
//  Description : One byte lane of storage (optionally carrying a parity bit).
//                Synchronous write, registered read-first read, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_sclk_lane
    import dpram_sclk_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rdata_q;

    // Array write and read register; a same-edge read sees the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dpram_sclk_bw.sv
// ============================================================================
//  Module      : dpram_sclk_bw
//  Description : Single-clock simple dual-port RAM with per-byte write
//                enables, read latency of 1 or 2, optional write/read bypass
//                and a post-reset clear sweep reported on init_done.
//                Optional feature macro: DPRAM_SCLK_PARITY_EN adds a stored
//                even-parity bit per lane, par_inject and parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_sclk_bw
    import dpram_sclk_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int ENABLE_BYPASS  = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    output logic                                     init_done,
    input  logic [ADDR_WIDTH-1:0]                    raddr,
    input  logic                                     re,
    input  logic [ADDR_WIDTH-1:0]                    waddr,
    input  logic                                     we,
    input  logic [nb_of(DATA_WIDTH, BYTE_WIDTH)-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]                    din,
    output logic [DATA_WIDTH-1:0]                    dout,
    output logic                                     dout_valid
`ifdef DPRAM_SCLK_PARITY_EN
    ,
    input  logic                                     par_inject,
    output logic                                     parity_err
`endif
);

    localparam int c_nb = nb_of(DATA_WIDTH, BYTE_WIDTH);
`ifdef DPRAM_SCLK_PARITY_EN
    localparam int c_par_w = 1;
`else
    localparam int c_par_w = 0;
`endif
    localparam int c_lane_w = BYTE_WIDTH + c_par_w;
    localparam dpram_state_t c_rst_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    // Reject unsupported configurations at elaboration time.
    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $fatal(1, "dpram_sclk_bw: RD_LATENCY must be 1 or 2");
        end
        if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
            $fatal(1, "dpram_sclk_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear sweep controller
    // ------------------------------------------------------------------
    dpram_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  init_done_q, init_done_d;
    logic                  w_clearing;

    // Next-state: walk clr_addr over every word, then open the memory.
    // init_done trails READY by one cycle so the last sweep write settles.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = (state_q == ST_READY);
        w_clearing  = 1'b0;
        if (state_q == ST_CLEAR) begin
            w_clearing = ~rst;
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) begin
                state_d = ST_READY;
            end
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_rst_state;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // ------------------------------------------------------------------
    // Port qualification and collision detect
    // ------------------------------------------------------------------
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_collide;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;

    assign w_wr_fire   = we & init_done_q & ~rst;
    assign w_rd_fire   = re & init_done_q;
    assign w_collide   = w_wr_fire & w_rd_fire & (waddr == raddr);
    assign w_mem_waddr = w_clearing ? clr_addr_q : waddr;

    // ------------------------------------------------------------------
    // Lane storage
    // ------------------------------------------------------------------
    logic [c_nb-1:0]       w_lane_we;
    logic [c_lane_w-1:0]   w_lane_wdata [c_nb];
    logic [c_lane_w-1:0]   w_lane_rdata [c_nb];
    logic [c_nb-1:0]       s1_byp_mask_q, s1_byp_mask_d;
    logic [DATA_WIDTH-1:0] s1_byp_data_q, s1_byp_data_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] w_s1_data;
`ifdef DPRAM_SCLK_PARITY_EN
    logic [c_nb-1:0]       w_lane_perr;
`endif

    generate
        for (genvar b = 0; b < c_nb; b++) begin : g_lane
            assign w_lane_we[b] = w_clearing | (w_wr_fire & wbe[b]);
`ifdef DPRAM_SCLK_PARITY_EN
            // Zero word with zero parity during the sweep; lane 0 parity can
            // be deliberately inverted to exercise the checker.
            assign w_lane_wdata[b] = w_clearing ? '0 :
                {even_par(c_lane_max'(din[b*BYTE_WIDTH +: BYTE_WIDTH]))
                     ^ ((b == 0) ? par_inject : 1'b0),
                 din[b*BYTE_WIDTH +: BYTE_WIDTH]};
            // A bypassed lane comes from din, so its stored parity is moot.
            assign w_lane_perr[b] = ~s1_byp_mask_q[b] &
                (even_par(c_lane_max'(w_lane_rdata[b][BYTE_WIDTH-1:0]))
                 != w_lane_rdata[b][BYTE_WIDTH]);
`else
            assign w_lane_wdata[b] = w_clearing ? '0 : din[b*BYTE_WIDTH +: BYTE_WIDTH];
`endif
            assign w_s1_data[b*BYTE_WIDTH +: BYTE_WIDTH] = s1_byp_mask_q[b]
                ? s1_byp_data_q[b*BYTE_WIDTH +: BYTE_WIDTH]
                : w_lane_rdata[b][BYTE_WIDTH-1:0];

            dpram_sclk_lane #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .WIDTH      (c_lane_w)
            ) u_lane (
                .clk   (clk),
                .we    (w_lane_we[b]),
                .waddr (w_mem_waddr),
                .wdata (w_lane_wdata[b]),
                .re    (w_rd_fire),
                .raddr (raddr),
                .rdata (w_lane_rdata[b])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read stage 1: capture bypass lanes alongside the array read
    // ------------------------------------------------------------------
    // Bypass info is captured only with an accepted read so that dout holds.
    always_comb begin
        s1_valid_d    = w_rd_fire;
        s1_byp_mask_d = s1_byp_mask_q;
        s1_byp_data_d = s1_byp_data_q;
        if (w_rd_fire) begin
            s1_byp_mask_d = ((ENABLE_BYPASS != 0) && w_collide) ? wbe : '0;
            s1_byp_data_d = din;
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_byp_mask_q <= '0;
            s1_byp_data_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_byp_mask_q <= s1_byp_mask_d;
            s1_byp_data_q <= s1_byp_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  dout_valid_q, dout_valid_d;
`ifdef DPRAM_SCLK_PARITY_EN
            logic                  parity_err_q, parity_err_d;
`endif

            // Pure pipeline register; dout only moves on a valid beat.
            always_comb begin
                dout_valid_d = s1_valid_q;
                dout_d       = s1_valid_q ? w_s1_data : dout_q;
`ifdef DPRAM_SCLK_PARITY_EN
                parity_err_d = s1_valid_q & (|w_lane_perr);
`endif
            end

            // Output registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
`ifdef DPRAM_SCLK_PARITY_EN
                    parity_err_q <= 1'b0;
`endif
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= dout_valid_d;
`ifdef DPRAM_SCLK_PARITY_EN
                    parity_err_q <= parity_err_d;
`endif
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
`ifdef DPRAM_SCLK_PARITY_EN
            assign parity_err = parity_err_q;
`endif
        end else begin : g_lat1
            logic has_data_q, has_data_d;

            // Lane read registers are not reset, so dout reads as zero until
            // the first accepted read has loaded them.
            always_comb begin
                has_data_d = has_data_q | w_rd_fire;
            end

            // Has-data flag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    has_data_q <= 1'b0;
                end else begin
                    has_data_q <= has_data_d;
                end
            end

            assign dout       = has_data_q ? w_s1_data : '0;
            assign dout_valid = s1_valid_q;
`ifdef DPRAM_SCLK_PARITY_EN
            assign parity_err = s1_valid_q & (|w_lane_perr);
`endif
        end
    endgenerate

endmodule

`default_nettype wire
